// File: rtl/i2s_receiver_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;

    localparam int I2S_SAMPLE_WIDTH = 16;
    localparam int I2S_MIN_BCLK_DIV = 6;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        SKIP,
        SHIFT,
        HOLD
    } i2s_state_t;

endpackage

// File: rtl/i2s_receiver_if.sv
// Codec-side serial lines plus the deserialised sample outputs of the I2S receiver.
interface i2s_receiver_if #(
    parameter int SAMPLE_WIDTH = i2s_pkg::I2S_SAMPLE_WIDTH
);
    logic                    bclk;
    logic                    lrclk;
    logic                    sdata;
    logic [SAMPLE_WIDTH-1:0] left_sample;
    logic [SAMPLE_WIDTH-1:0] right_sample;
    logic [SAMPLE_WIDTH-1:0] mono_sample;
    logic                    sample_valid;
    logic                    frame_error;

    modport master (
        output bclk, lrclk, sdata,
        input  left_sample, right_sample, mono_sample, sample_valid, frame_error
    );

    modport slave (
        input  bclk, lrclk, sdata,
        output left_sample, right_sample, mono_sample, sample_valid, frame_error
    );
endinterface

// File: rtl/i2s_receiver_sync_edge_detect.sv
// Multi-stage synchroniser for an asynchronous level with a registered one-cycle rise tick.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign o_rise = r_rise;
endmodule

// File: rtl/i2s_receiver.sv
// Slave I2S receiver: oversamples BCLK/LRCLK/SDATA and emits 16-bit stereo pairs.
// Optional I2S_RX_MONO_SUM_EN adds a registered (L+R)>>>1 mono output.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
    parameter int SYNC_STAGES  = 2
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    i2s_receiver_if.slave bus
);
    localparam int            CW       = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(SAMPLE_WIDTH - 1);

    i2s_state_t              r_state;
    i2s_state_t              w_state_next;
    logic [SYNC_STAGES-1:0]  r_lrclk_sync;
    logic [SYNC_STAGES-1:0]  r_sdata_sync;
    logic                    w_bclk_rise;
    logic                    w_lrclk_s;
    logic                    w_sdata_s;
    logic                    w_lr_edge;
    logic                    w_latch;
    logic                    w_short;
    logic                    w_emit_pair;
    logic                    r_lrclk_prev;
    logic                    r_lr_seen;
    logic                    r_left_valid;
    logic                    r_sample_valid;
    logic                    r_frame_error;
    logic [CW-1:0]           r_bit_cnt;
    logic [SAMPLE_WIDTH-2:0] r_shift;
    logic [SAMPLE_WIDTH-1:0] w_word;
    logic [SAMPLE_WIDTH-1:0] r_left_hold;
    logic [SAMPLE_WIDTH-1:0] r_left;
    logic [SAMPLE_WIDTH-1:0] r_right;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
        .i_clk   (CLOCK_50),
        .i_rst   (reset),
        .i_async (bus.bclk),
        .o_rise  (w_bclk_rise)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_lrclk_sync <= '0;
            r_sdata_sync <= '0;
        end else begin
            r_lrclk_sync <= {r_lrclk_sync[SYNC_STAGES-2:0], bus.lrclk};
            r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], bus.sdata};
        end
    end

    assign w_lrclk_s   = r_lrclk_sync[SYNC_STAGES-1];
    assign w_sdata_s   = r_sdata_sync[SYNC_STAGES-1];
    assign w_word      = {r_shift, w_sdata_s};
    assign w_emit_pair = w_latch && w_lrclk_s && r_left_valid;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) r_state <= WAIT_SYNC;
        else       r_state <= w_state_next;
    end

    // The rise that reveals a new LRCLK level is the delay bit itself, so SKIP
    // only needs one clock to arm SHIFT before the MSB rise arrives.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_short      = 1'b0;
        w_lr_edge    = w_bclk_rise && r_lr_seen && (w_lrclk_s != r_lrclk_prev);
        case (r_state)
            WAIT_SYNC: if (w_lr_edge) w_state_next = SKIP;
            SKIP:      w_state_next = SHIFT;
            SHIFT: begin
                if (w_lr_edge) begin
                    w_short      = 1'b1;
                    w_state_next = SKIP;
                end else if (w_bclk_rise && (r_bit_cnt == LAST_BIT)) begin
                    w_latch      = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD:      if (w_lr_edge) w_state_next = SKIP;
            default:   w_state_next = WAIT_SYNC;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_lrclk_prev   <= 1'b0;
            r_lr_seen      <= 1'b0;
            r_left_valid   <= 1'b0;
            r_sample_valid <= 1'b0;
            r_frame_error  <= 1'b0;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_left_hold    <= '0;
            r_left         <= '0;
            r_right        <= '0;
        end else begin
            r_sample_valid <= 1'b0;
            r_frame_error  <= 1'b0;
            if (w_bclk_rise) begin
                r_lrclk_prev <= w_lrclk_s;
                r_lr_seen    <= 1'b1;
            end
            if (r_state == SKIP) begin
                r_bit_cnt <= '0;
            end else if ((r_state == SHIFT) && w_bclk_rise && !w_short) begin
                r_shift   <= w_word[SAMPLE_WIDTH-2:0];
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_short) begin
                r_frame_error <= 1'b1;
                r_left_valid  <= 1'b0;
            end
            if (w_latch && !w_lrclk_s) begin
                r_left_hold  <= w_word;
                r_left_valid <= 1'b1;
            end else if (w_latch) begin
                r_left_valid <= 1'b0;
            end
            if (w_emit_pair) begin
                r_left         <= r_left_hold;
                r_right        <= w_word;
                r_sample_valid <= 1'b1;
            end
        end
    end

    assign bus.left_sample  = r_left;
    assign bus.right_sample = r_right;
    assign bus.sample_valid = r_sample_valid;
    assign bus.frame_error  = r_frame_error;

`ifdef I2S_RX_MONO_SUM_EN
    logic [SAMPLE_WIDTH-1:0] r_mono;
    logic [SAMPLE_WIDTH-1:0] w_mono_next;

    assign w_mono_next = SAMPLE_WIDTH'(($signed({r_left_hold[SAMPLE_WIDTH-1], r_left_hold})
                                      + $signed({w_word[SAMPLE_WIDTH-1], w_word})) >>> 1);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)            r_mono <= '0;
        else if (w_emit_pair) r_mono <= w_mono_next;
    end

    assign bus.mono_sample = r_mono;
`else
    assign bus.mono_sample = '0;
`endif
endmodule

// File: tb/tb_i2s_receiver.sv
// Directed I2S frames driven into i2s_receiver; a monitor pops expected pairs/errors as the DUT strobes.
module tb_i2s_receiver;
    localparam int SW   = 16;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 2;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] m;
        int unsigned at;
    } exp_t;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          half = 4;
    bit          done = 1'b0;
    exp_t        exp_q[$];
    int unsigned err_q[$];

    i2s_receiver_if #(.SAMPLE_WIDTH(SW)) bus ();

    i2s_receiver #(.SAMPLE_WIDTH(SW), .SYNC_STAGES(SYNC)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    function automatic logic [15:0] mono_exp(input logic [15:0] v);
`ifdef I2S_RX_MONO_SUM_EN
        return v;
`else
        return 16'h0000 & v;
`endif
    endfunction

    function automatic logic [15:0] mono_of(input logic [15:0] l, input logic [15:0] r);
        logic [16:0] s;
        s = {l[15], l} + {r[15], r};
        return mono_exp(s[16:1]);
    endfunction

    // One bclk period: low phase with new lrclk/sdata, then high phase.
    task automatic bit_out(input logic lr, input logic d, input bit push_v, input exp_t e, input bit push_err);
        exp_t ex;
        @(negedge CLOCK_50);
        bus.bclk  = 1'b0;
        bus.lrclk = lr;
        bus.sdata = d;
        repeat (half - 1) @(negedge CLOCK_50);
        bus.bclk = 1'b1;
        if (push_v) begin
            ex    = e;
            ex.at = cyc + LAT;
            exp_q.push_back(ex);
        end
        if (push_err) err_q.push_back(cyc + LAT);
        repeat (half - 1) @(negedge CLOCK_50);
    endtask

    // Bit 0 of a slot is the delay bit; data follows MSB first from w[31].
    task automatic send_slot(input logic lr, input logic [31:0] w, input int nbits,
                             input bit want, input exp_t e, input bit want_err);
        for (int i = 0; i < nbits; i++) begin
            logic d;
            d = (i >= 1 && i <= 32) ? w[32 - i] : 1'b0;
            bit_out(lr, d, want && (i == SW), e, want_err && (i == 0));
        end
    endtask

    task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw, input int nbits, input bit want,
                              input logic [15:0] el, input logic [15:0] er, input logic [15:0] em);
        exp_t e;
        e.l  = el;
        e.r  = er;
        e.m  = em;
        e.at = 0;
        send_slot(1'b0, lw, nbits, 1'b0, e, 1'b0);
        send_slot(1'b1, rw, nbits, want, e, 1'b0);
    endtask

    initial begin : driver
        exp_t        e0;
        logic [15:0] l;
        logic [15:0] r;
        e0.l  = '0;
        e0.r  = '0;
        e0.m  = '0;
        e0.at = 0;
        bus.bclk  = 1'b0;
        bus.lrclk = 1'b0;
        bus.sdata = 1'b0;
        reset     = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        reset = 1'b0;

        // Partial left, then a right slot that syncs but has no left partner.
        send_slot(1'b0, 32'h0, 5, 1'b0, e0, 1'b0);
        send_slot(1'b1, 32'hEDCB_0000, 32, 1'b0, e0, 1'b0);
        send_frame(32'h1234_0000, 32'hEDCB_0000, 32, 1'b1, 16'h1234, 16'hEDCB, mono_exp(16'hFFFF));
        send_frame(32'h1234_0000, 32'hEDCB_0000, 32, 1'b1, 16'h1234, 16'hEDCB, mono_exp(16'hFFFF));
        send_frame(32'h7FFF_0000, 32'h8000_0000, 32, 1'b1, 16'h7FFF, 16'h8000, mono_exp(16'hFFFF));
        send_frame(32'hABCD_EF00, 32'h1234_5600, 32, 1'b1, 16'hABCD, 16'h1234, mono_exp(16'hDF00));

        // Short left slot: error at the right delay bit, pair dropped, next frame fine.
        send_slot(1'b0, 32'h1111_0000, 10, 1'b0, e0, 1'b0);
        send_slot(1'b1, 32'h2222_0000, 32, 1'b0, e0, 1'b1);
        send_frame(32'h0003_0000, 32'h0004_0000, 32, 1'b1, 16'h0003, 16'h0004, mono_exp(16'h0003));

        // Reset in the middle of a right slot, then resume the stream.
        send_slot(1'b0, 32'h5555_0000, 32, 1'b0, e0, 1'b0);
        send_slot(1'b1, 32'hAAAA_0000, 10, 1'b0, e0, 1'b0);
        @(negedge CLOCK_50);
        bus.bclk = 1'b0;
        reset    = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        send_slot(1'b1, 32'hAAAA_0000, 20, 1'b0, e0, 1'b0);
        send_frame(32'h4000_0000, 32'h2000_0000, 32, 1'b1, 16'h4000, 16'h2000, mono_exp(16'h3000));

        // Fastest bclk with minimum-length slots.
        half = 3;
        for (int i = 0; i < 100; i++) begin
            l = 16'(i * 16'h0137 + 16'h0001);
            r = ~16'(i * 16'h0091);
            send_frame({l, 16'h0000}, {r, 16'h0000}, SW + 1, 1'b1, l, r, mono_of(l, r));
        end
        repeat (20) @(negedge CLOCK_50);
        done = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    initial begin : monitor
        bit          prev_v;
        bit          prev_e;
        exp_t        e;
        int unsigned ea;
        prev_v = 1'b0;
        prev_e = 1'b0;
        forever begin
            @(negedge CLOCK_50 or posedge reset);
            #1;
            if (reset) begin
                chk("rst_left",  32'(bus.left_sample), 32'h0);
                chk("rst_right", 32'(bus.right_sample), 32'h0);
                chk("rst_mono",  32'(bus.mono_sample), 32'h0);
                chk("rst_valid", 32'(bus.sample_valid), 32'h0);
                chk("rst_ferr",  32'(bus.frame_error), 32'h0);
            end else begin
                if (bus.sample_valid) begin
                    chk("valid_width", 32'(prev_v), 32'h0);
                    chk("valid_err_excl", 32'(bus.frame_error), 32'h0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 32'(bus.sample_valid), 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("left",    32'(bus.left_sample), 32'(e.l));
                        chk("right",   32'(bus.right_sample), 32'(e.r));
                        chk("mono",    32'(bus.mono_sample), 32'(e.m));
                        chk("latency", cyc, e.at);
                        $display("pair L=%h R=%h M=%h at cycle %0d", bus.left_sample, bus.right_sample,
                                 bus.mono_sample, cyc);
                    end
                end
                if (bus.frame_error) begin
                    chk("ferr_width", 32'(prev_e), 32'h0);
                    if (err_q.size() == 0) begin
                        chk("unexpected_ferr", 32'(bus.frame_error), 32'h0);
                    end else begin
                        ea = err_q.pop_front();
                        chk("ferr_latency", cyc, ea);
                        $display("frame_error at cycle %0d", cyc);
                    end
                end
            end
            prev_v = bus.sample_valid;
            prev_e = bus.frame_error;
            if (done) begin
                chk("missing_valid", exp_q.size(), 32'h0);
                chk("missing_ferr",  err_q.size(), 32'h0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end
endmodule
